// File: rtl/dig_clock_pkg.sv
// Shared definitions for the digital clock's button handling.
//
// Contents:
//   btn_state_e   - 2-bit encoding of the button-press FSM (ARM, IDLE, SHORT, REPEAT)
//   LONG_MS_DEF   - default hold time, in count-enabled cycles, before auto-repeat
//   REPEAT_MS_DEF - default auto-repeat interval, in count-enabled cycles
package dig_clock_pkg;

  typedef enum logic [1:0] {
    ST_ARM    = 2'd0,
    ST_IDLE   = 2'd1,
    ST_SHORT  = 2'd2,
    ST_REPEAT = 2'd3
  } btn_state_e;

  localparam int LONG_MS_DEF   = 1000;
  localparam int REPEAT_MS_DEF = 200;

endpackage

// File: rtl/btn_hold_timer.sv
// Hold-duration counter for the button-press controller.
//
// Ports:
//   i_clk  - clock, rising edge
//   i_rst  - synchronous active-high reset, clears the count
//   i_clr  - synchronous clear (wins over i_en)
//   i_en   - advance the count by one
//   i_term - terminal value, compared on the full CNT_W width
//   o_hit  - high while the current count equals i_term
//
// The owner clears the counter on state entry and at every terminal count,
// so the count never reaches a wrap.
module btn_hold_timer
  import dig_clock_pkg::*;
#(
  parameter int CNT_W = 10
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_term,
  output logic             o_hit
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_hit = (r_cnt == i_term);

endmodule

// File: rtl/btn_press_ctrl.sv
// Button-press controller: turns the debounced button level into press,
// step (with long-press auto-repeat), short-click and release events.
//
// Ports:
//   CLK       - system clock (1 kHz in the clock design), rising edge
//   rst       - synchronous active-high reset
//   en        - count enable for the hold timer
//   i_btn     - debounced button level, 1 = pressed
//   o_press   - one-cycle pulse when a press is accepted
//   o_step    - one-cycle pulse on press, at the long-press threshold and
//               at every repeat interval after that
//   o_long    - level, high while auto-repeating
//   o_short   - one-cycle pulse on release before the long-press threshold
//   o_release - one-cycle pulse on any release of an accepted press
//
// All outputs come straight from registers.
module btn_press_ctrl
  import dig_clock_pkg::*;
#(
  parameter int LONG_MS   = LONG_MS_DEF,
  parameter int REPEAT_MS = REPEAT_MS_DEF,
  parameter int CNT_W     = 10
) (
  input  logic CLK,
  input  logic rst,
  input  logic en,
  input  logic i_btn,
  output logic o_press,
  output logic o_step,
  output logic o_long,
  output logic o_short,
  output logic o_release
);

  localparam logic [CNT_W-1:0] LONG_TERM = CNT_W'(LONG_MS - 1);
  localparam logic [CNT_W-1:0] REP_TERM  = CNT_W'(REPEAT_MS - 1);

  btn_state_e       r_state;
  btn_state_e       w_state_nxt;
  logic             r_press, r_step, r_long, r_short, r_release;
  logic             w_press, w_step, w_long, w_short, w_release;
  logic             w_clr;
  logic             w_cnt_en;
  logic             w_hit;
  logic [CNT_W-1:0] w_term;

  assign w_term = (r_state == ST_REPEAT) ? REP_TERM : LONG_TERM;

  btn_hold_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .i_clk  (CLK),
    .i_rst  (rst),
    .i_clr  (w_clr),
    .i_en   (w_cnt_en),
    .i_term (w_term),
    .o_hit  (w_hit)
  );

  // Timer is held cleared outside SHORT/REPEAT, so it always starts from 0
  // on entry; in SHORT/REPEAT it is cleared again at each terminal count.
  // Release is checked first so it beats a terminal count on the same edge.
  always_comb begin
    w_state_nxt = r_state;
    w_press     = 1'b0;
    w_step      = 1'b0;
    w_long      = 1'b0;
    w_short     = 1'b0;
    w_release   = 1'b0;
    w_clr       = 1'b1;
    w_cnt_en    = 1'b0;
    case (r_state)
      ST_ARM: begin
        // A button held through reset must be let go before it counts.
        if (!i_btn) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (i_btn) begin
          w_state_nxt = ST_SHORT;
          w_press     = 1'b1;
          w_step      = 1'b1;
        end
      end
      ST_SHORT: begin
        if (!i_btn) begin
          w_state_nxt = ST_IDLE;
          w_release   = 1'b1;
          w_short     = 1'b1;
        end else begin
          w_clr = 1'b0;
          if (en) begin
            if (w_hit) begin
              w_state_nxt = ST_REPEAT;
              w_step      = 1'b1;
              w_long      = 1'b1;
              w_clr       = 1'b1;
            end else begin
              w_cnt_en = 1'b1;
            end
          end
        end
      end
      ST_REPEAT: begin
        if (!i_btn) begin
          w_state_nxt = ST_IDLE;
          w_release   = 1'b1;
        end else begin
          w_long = 1'b1;
          w_clr  = 1'b0;
          if (en) begin
            if (w_hit) begin
              w_step = 1'b1;
              w_clr  = 1'b1;
            end else begin
              w_cnt_en = 1'b1;
            end
          end
        end
      end
      default: begin
        w_state_nxt = ST_ARM;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      r_state   <= ST_ARM;
      r_press   <= 1'b0;
      r_step    <= 1'b0;
      r_long    <= 1'b0;
      r_short   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_press   <= w_press;
      r_step    <= w_step;
      r_long    <= w_long;
      r_short   <= w_short;
      r_release <= w_release;
    end
  end

  assign o_press   = r_press;
  assign o_step    = r_step;
  assign o_long    = r_long;
  assign o_short   = r_short;
  assign o_release = r_release;

endmodule

// File: tb/tb_btn_press_ctrl.sv
// Directed bench for btn_press_ctrl with LONG_MS=5, REPEAT_MS=3.
// Output vectors are packed as {press, step, long, short, release}.
module tb_btn_press_ctrl;

  logic CLK = 1'b0;
  logic rst, en, i_btn;
  logic o_press, o_step, o_long, o_short, o_release;
  int   total = 0;
  int   bad   = 0;

  always #5 CLK = ~CLK;

  btn_press_ctrl #(
    .LONG_MS   (5),
    .REPEAT_MS (3),
    .CNT_W     (10)
  ) dut (
    .CLK       (CLK),
    .rst       (rst),
    .en        (en),
    .i_btn     (i_btn),
    .o_press   (o_press),
    .o_step    (o_step),
    .o_long    (o_long),
    .o_short   (o_short),
    .o_release (o_release)
  );

  // Advance one rising edge, then settle before sampling.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [4:0] exp);
    logic [4:0] obs;
    obs = {o_press, o_step, o_long, o_short, o_release};
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Drive inputs, take one edge, check the registered outputs of that edge.
  task automatic cyc(input logic b, input logic e, input string tag,
                     input logic [4:0] exp);
    i_btn = b;
    en    = e;
    tick();
    chk(tag, exp);
  endtask

  initial begin
    logic [4:0] exp;
    rst   = 1'b1;
    en    = 1'b1;
    i_btn = 1'b0;
    tick();
    chk("reset", 5'b00000);
    tick();
    rst = 1'b0;
    cyc(0, 1, "arm_to_idle", 5'b00000);

    // Short click: 3 high cycles.
    cyc(1, 1, "sc_press",   5'b11000);
    cyc(1, 1, "sc_hold1",   5'b00000);
    cyc(1, 1, "sc_hold2",   5'b00000);
    cyc(0, 1, "sc_release", 5'b00011);
    cyc(0, 1, "sc_quiet",   5'b00000);

    // Long hold: 15 high cycles, steps at 1, 6, 9, 12, 15.
    for (int i = 1; i <= 15; i++) begin
      if (i == 1)                           exp = 5'b11000;
      else if (i < 6)                       exp = 5'b00000;
      else if (i == 6 || i == 9 || i == 12 || i == 15) exp = 5'b01100;
      else                                  exp = 5'b00100;
      cyc(1, 1, $sformatf("lh_c%0d", i), exp);
    end
    cyc(0, 1, "lh_release", 5'b00001);
    cyc(0, 1, "lh_quiet",   5'b00000);

    // Enable gating: en high on odd cycles only; second step at cycle 11.
    for (int i = 1; i <= 11; i++) begin
      if (i == 1)       exp = 5'b11000;
      else if (i == 11) exp = 5'b01100;
      else              exp = 5'b00000;
      cyc(1, logic'(i % 2), $sformatf("eg_c%0d", i), exp);
    end
    cyc(0, 0, "eg_release_en0", 5'b00001);
    cyc(0, 1, "eg_quiet",       5'b00000);

    // Release on the edge where the SHORT count sits at its terminal value.
    cyc(1, 1, "rt_press", 5'b11000);
    for (int i = 2; i <= 5; i++) cyc(1, 1, $sformatf("rt_c%0d", i), 5'b00000);
    cyc(0, 1, "rt_release", 5'b00011);
    cyc(0, 1, "rt_quiet",   5'b00000);
    cyc(1, 1, "rt_idle_press",   5'b11000);
    cyc(0, 1, "rt_idle_release", 5'b00011);

    // Reset while auto-repeating with the button held throughout.
    cyc(1, 1, "rr_press", 5'b11000);
    for (int i = 2; i <= 5; i++) cyc(1, 1, $sformatf("rr_c%0d", i), 5'b00000);
    cyc(1, 1, "rr_long",  5'b01100);
    cyc(1, 1, "rr_hold",  5'b00100);
    rst = 1'b1;
    cyc(1, 1, "rr_rst1",  5'b00000);
    cyc(1, 1, "rr_rst2",  5'b00000);
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) cyc(1, 1, $sformatf("rr_arm%0d", i), 5'b00000);
    cyc(0, 1, "rr_let_go",    5'b00000);
    cyc(1, 1, "rr_new_press", 5'b11000);
    cyc(0, 1, "rr_new_rel",   5'b00011);

    // Back-to-back single-cycle presses.
    cyc(1, 1, "bb_press1", 5'b11000);
    cyc(0, 1, "bb_rel1",   5'b00011);
    cyc(1, 1, "bb_press2", 5'b11000);
    cyc(0, 1, "bb_rel2",   5'b00011);
    cyc(0, 1, "bb_quiet",  5'b00000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/btn_press_ctrl.md
Name: btn_press_ctrl

Overview:
- Sits directly downstream of the 1 kHz button debouncer; consumes its debounced level output.
- Converts the level into discrete clock-setting events:
  - a press pulse;
  - a step pulse on press and then auto-repeat steps while the button is held (long press);
  - a release pulse, and a short-click pulse for a press that ends before the long-press threshold.
- Feeds the time-set / mode logic of the digital clock.

Parameters:
- LONG_MS, 1000, count-enabled cycles the button must be held before auto-repeat starts; legal range 2..2^CNT_W.
- REPEAT_MS, 200, count-enabled cycles between auto-repeat step pulses; legal range 2..2^CNT_W.
- CNT_W, 10, hold-counter width.

Ports:
- CLK, input, 1, system clock (1 kHz in the clock design); all logic on the rising edge.
- rst, input, 1, synchronous, active-high reset.
- en, input, 1, count enable; the hold counter advances only when en=1.
- i_btn, input, 1, debounced button level (1 = pressed).
- o_press, output, 1, one-cycle pulse when a press is accepted.
- o_step, output, 1, one-cycle pulse on press, at the long-press threshold, and at each repeat interval.
- o_long, output, 1, level; high while in the auto-repeat state.
- o_short, output, 1, one-cycle pulse on release from SHORT only.
- o_release, output, 1, one-cycle pulse on any release from SHORT or REPEAT.

Behaviour:
- All outputs are registered; no combinational path from input to output.
- Reset (rst=1 at a clock edge):
  - state becomes ARM, counter clears to 0, all outputs 0.
  - Reset mid-press produces no release or short pulse.
- States: ARM, IDLE, SHORT, REPEAT.
  - ARM: the button is ignored until i_btn=0 is sampled, so a button held through reset never generates a press.
    - i_btn=0 -> IDLE.
  - IDLE: when i_btn=1 is sampled at edge N -> SHORT, counter=0.
    - o_press=1 and o_step=1 are visible after edge N, for exactly one cycle.
  - SHORT, evaluated in this priority order:
    - i_btn=0 -> IDLE; o_release=1 and o_short=1 for one cycle. Release does not depend on en.
    - i_btn=1, en=1, counter==LONG_MS-1 -> REPEAT; counter=0, o_step=1 for one cycle, o_long=1.
    - i_btn=1, en=1, otherwise -> counter+1.
    - en=0 -> counter holds.
  - REPEAT, evaluated in this priority order:
    - i_btn=0 -> IDLE; o_release=1 for one cycle, o_long=0 on the same edge, no o_short.
    - i_btn=1, en=1, counter==REPEAT_MS-1 -> counter=0, o_step=1 for one cycle, stay in REPEAT.
    - i_btn=1, en=1, otherwise -> counter+1.
    - en=0 -> hold.
- Latency with en=1 every cycle:
  - first o_step follows the press edge;
  - second o_step comes exactly LONG_MS cycles after the first;
  - later o_step pulses come every REPEAT_MS cycles.
- Release on the same edge the terminal count is reached: release wins; no o_step and no transition to REPEAT.
- The counter never wraps:
  - it is cleared on every state entry and at each terminal count;
  - the comparison is on the full CNT_W width.
- Back-to-back events: a re-press is accepted in the cycle after returning to IDLE, giving minimum press spacing of 2 cycles.
- Unreachable state encodings recover to ARM, with all pulses 0.

Decomposition:
- Shared package dig_clock_pkg holds:
  - the state encoding constants (ARM, IDLE, SHORT, REPEAT, 2 bits);
  - the default LONG_MS and REPEAT_MS constants.
- One natural sub-module, btn_hold_timer:
  - inputs: clear, enable, terminal value;
  - output: terminal-reached flag;
  - parameterised by CNT_W.
- The FSM and output registers stay in btn_press_ctrl.

Test Plan (LONG_MS=5, REPEAT_MS=3, en=1 unless stated):
- Short click: i_btn high 3 cycles then low.
  - o_press/o_step pulse once after the first high edge.
  - o_short and o_release pulse once after the first low edge.
  - o_long stays 0.
- Long hold: i_btn high 15 cycles.
  - o_step pulses at cycles 1, 6, 9, 12, 15 relative to the press edge.
  - o_long rises with the cycle-6 pulse.
  - Release gives o_release=1, o_short=0, and o_long=0 on the same edge.
- Enable gating: en toggles 1/0 each cycle while held.
  - The second o_step comes 10 cycles after the first.
  - Release while en=0 still returns to IDLE with o_release.
- Release on the terminal edge: i_btn falls at the edge where the SHORT counter==4.
  - No o_step, o_short=1, state returns to IDLE.
- Reset mid-REPEAT with i_btn held through reset.
  - All outputs 0 during and after reset.
  - No o_press until i_btn has gone low and then high again.
  - That new press produces normal pulses.
- Back-to-back: press 1 cycle, low 1 cycle, press 1 cycle.
  - Two separate o_press pulses and two o_short pulses.
